qam_frame_scheduler: RTL and testbench

- Sequences symbol issue for the 64-QAM transmit path at a programmable symbol rate.
- Per frame, it emits a fixed preamble, then exactly frame_len payload symbols popped from the I/Q data FIFO, then signals completion.
- Sits between the I/Q symbol FIFO (fed by the baseband mapper) and the I/Q modulator/DAC stage.
- FIFO underrun stalls the symbol stream and raises a sticky flag.

---
 rtl/qam_frame_scheduler_if.sv | 32 +++
 rtl/qam_frame_scheduler.sv | 151 +++++++++++++++
 tb/tb_qam_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_frame_scheduler_if.sv
// Control, FIFO and symbol-output signal bundle of the 64-QAM frame scheduler.
interface qam_frame_scheduler_if #(
    parameter int unsigned SYM_PERIOD_W = 8,
    parameter int unsigned FRAME_LEN_W  = 10
);
    logic                    start;
    logic                    abort;
    logic [FRAME_LEN_W-1:0]  frame_len;
    logic [SYM_PERIOD_W-1:0] sym_period;
    logic                    fifo_empty;
    logic [3:0]              fifo_i;
    logic [3:0]              fifo_q;
    logic                    fifo_rd_en;
    logic                    sym_valid;
    logic [3:0]              sym_i;
    logic [3:0]              sym_q;
    logic                    busy;
    logic                    done;
    logic                    underrun;

    // Surrounding system: frame control, FIFO head, downstream consumer.
    modport master (
        output start, abort, frame_len, sym_period, fifo_empty, fifo_i, fifo_q,
        input  fifo_rd_en, sym_valid, sym_i, sym_q, busy, done, underrun
    );

    // The scheduler itself.
    modport slave (
        input  start, abort, frame_len, sym_period, fifo_empty, fifo_i, fifo_q,
        output fifo_rd_en, sym_valid, sym_i, sym_q, busy, done, underrun
    );
endinterface

// File: rtl/qam_frame_scheduler.sv
// 64-QAM frame scheduler: preamble, then frame_len FIFO symbols at a programmable rate.
module qam_frame_scheduler #(
    parameter int unsigned SYM_PERIOD_W = 8,
    parameter int unsigned FRAME_LEN_W  = 10,
    parameter int unsigned PREAMBLE_LEN = 8
) (
    input  logic                  data_clk,
    input  logic                  rst_n,
    qam_frame_scheduler_if.slave  bus
);
    localparam int unsigned PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SYM_PERIOD_W-1:0] tick_q, tick_d;
    logic [SYM_PERIOD_W-1:0] period_q, period_d;
    logic [FRAME_LEN_W-1:0]  flen_q, flen_d;
    logic [FRAME_LEN_W-1:0]  pay_q, pay_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [3:0]              sym_i_q, sym_i_d;
    logic [3:0]              sym_q_q, sym_q_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    underrun_q, underrun_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_en;
    logic                    tick;

    // Next-state, counter and symbol selection logic.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        period_d    = period_q;
        flen_d      = flen_q;
        pay_d       = pay_q;
        pre_d       = pre_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        sym_valid_d = 1'b0;
        underrun_d  = underrun_q;
        rd_en       = 1'b0;
        tick        = (tick_q == period_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    flen_d     = bus.frame_len;
                    period_d   = bus.sym_period;
                    underrun_d = 1'b0;
                    tick_d     = '0;
                    pre_d      = '0;
                    pay_d      = '0;
                    state_d    = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    sym_valid_d = 1'b1;
                    sym_i_d     = pre_q[0] ? 4'h0 : 4'h7;
                    sym_q_d     = pre_q[0] ? 4'h0 : 4'h7;
                    tick_d      = '0;
                    pre_d       = pre_q + PRE_W'(1);
                    if (pre_q == PRE_W'(PREAMBLE_LEN - 1)) begin
                        state_d = (flen_q == '0) ? ST_DONE : ST_PAYLOAD;
                    end
                end else begin
                    tick_d = tick_q + SYM_PERIOD_W'(1);
                end
            end
            ST_PAYLOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    // Tick counter parks at the period while the FIFO is empty.
                    if (!bus.fifo_empty) begin
                        rd_en       = 1'b1;
                        sym_valid_d = 1'b1;
                        sym_i_d     = bus.fifo_i;
                        sym_q_d     = bus.fifo_q;
                        tick_d      = '0;
                        pay_d       = pay_q + FRAME_LEN_W'(1);
                        if (pay_q == flen_q - FRAME_LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + SYM_PERIOD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PREAMBLE) || (state_d == ST_PAYLOAD);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge data_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            period_q    <= '0;
            flen_q      <= '0;
            pay_q       <= '0;
            pre_q       <= '0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            period_q    <= period_d;
            flen_q      <= flen_d;
            pay_q       <= pay_d;
            pre_q       <= pre_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_valid_q <= sym_valid_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // A reset cycle must never pop the FIFO, even before the state register clears.
    assign bus.fifo_rd_en = rd_en && rst_n;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.sym_i      = sym_i_q;
    assign bus.sym_q      = sym_q_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_qam_frame_scheduler.sv
// Directed scoreboard bench for qam_frame_scheduler.
module tb_qam_frame_scheduler;
    localparam int unsigned SYM_PERIOD_W = 8;
    localparam int unsigned FRAME_LEN_W  = 10;
    localparam int unsigned PREAMBLE_LEN = 8;

    logic data_clk = 1'b0;
    logic rst_n;

    always #5 data_clk = ~data_clk;

    qam_frame_scheduler_if #(.SYM_PERIOD_W(SYM_PERIOD_W), .FRAME_LEN_W(FRAME_LEN_W)) bus ();

    qam_frame_scheduler #(
        .SYM_PERIOD_W(SYM_PERIOD_W),
        .FRAME_LEN_W (FRAME_LEN_W),
        .PREAMBLE_LEN(PREAMBLE_LEN)
    ) dut (
        .data_clk(data_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // First-word-fall-through FIFO model.
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (rd_ptr >= wr_ptr);
    assign bus.fifo_i     = mem[rd_ptr[9:0]][7:4];
    assign bus.fifo_q     = mem[rd_ptr[9:0]][3:0];

    logic [7:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int t_start = 0;
    int n_valid, n_pop, n_done, n_busy;
    int first_valid, last_valid, last_pop, done_at;
    int exp_gap;
    bit chk_gap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then cross the rising edge.
    task automatic cyc();
        logic [7:0] e;
        bit pop;
        @(negedge data_clk);
        pop = 1'b0;
        if (bus.sym_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_strobe", 32'(bus.sym_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sym", {24'd0, bus.sym_i, bus.sym_q}, {24'd0, e});
            end
            if (chk_gap && last_valid >= 0) check("gap", 32'(cyc_n - last_valid), 32'(exp_gap));
            if (first_valid < 0) first_valid = cyc_n;
            last_valid = cyc_n;
            n_valid++;
        end
        if (bus.fifo_rd_en === 1'b1) begin
            check("rd_en_while_empty", 32'(bus.fifo_empty), 32'd0);
            pop = 1'b1;
            n_pop++;
            last_pop = cyc_n;
        end
        if (bus.busy === 1'b1) n_busy++;
        if (bus.done === 1'b1) begin
            n_done++;
            done_at = cyc_n;
        end
        @(posedge data_clk);
        cyc_n++;
        #1;
        if (pop) rd_ptr++;
    endtask

    task automatic reset_stats();
        n_valid = 0; n_pop = 0; n_done = 0; n_busy = 0;
        first_valid = -1; last_valid = -1; last_pop = -1; done_at = -1;
        exp_q.delete();
    endtask

    task automatic push_fifo(input logic [3:0] i, input logic [3:0] q);
        mem[wr_ptr[9:0]] = {i, q};
        wr_ptr++;
    endtask

    task automatic push_preamble(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back((k % 2 == 0) ? 8'h77 : 8'h00);
    endtask

    task automatic start_frame(input int flen, input int per);
        bus.frame_len  = FRAME_LEN_W'(flen);
        bus.sym_period = SYM_PERIOD_W'(per);
        bus.start      = 1'b1;
        cyc();
        bus.start      = 1'b0;
        t_start        = cyc_n;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (n_done == 0 && n < budget) begin
            cyc();
            n++;
        end
        if (n_done == 0) check("timeout_done", 32'(n_done), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sym_valid"}, 32'(bus.sym_valid), 32'd0);
        check({tag, "_sym_i"}, 32'(bus.sym_i), 32'd0);
        check({tag, "_sym_q"}, 32'(bus.sym_q), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.frame_len = '0;
        bus.sym_period = '0;
        reset_stats();
        chk_gap = 1'b0;
        exp_gap = 0;

        // Reset state
        repeat (3) cyc();
        check_zero_outputs("reset");
        check("reset_underrun", 32'(bus.underrun), 32'd0);
        rst_n = 1'b1;
        cyc();

        // start together with abort is ignored
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.frame_len = FRAME_LEN_W'(4);
        cyc();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc();
        check("start_abort_ignored", 32'(bus.busy), 32'd0);

        // Frame 1: P=3, frame_len=4, prefilled FIFO, start pulse mid-frame
        reset_stats();
        push_fifo(4'h1, 4'h2); push_fifo(4'h3, 4'h4); push_fifo(4'h5, 4'h6); push_fifo(4'h7, 4'h8);
        push_preamble(8);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        chk_gap = 1'b1;
        exp_gap = 4;
        start_frame(4, 3);
        repeat (6) cyc();
        bus.frame_len = FRAME_LEN_W'(7);
        bus.sym_period = SYM_PERIOD_W'(0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run_to_done(200);
        repeat (3) cyc();
        check("f1_first_valid", 32'(first_valid - t_start), 32'd4);
        check("f1_n_valid", 32'(n_valid), 32'd12);
        check("f1_n_pop", 32'(n_pop), 32'd4);
        check("f1_n_done", 32'(n_done), 32'd1);
        check("f1_done_after_pop", 32'(done_at - last_pop), 32'd1);
        check("f1_n_busy", 32'(n_busy), 32'd48);
        check("f1_underrun", 32'(bus.underrun), 32'd0);
        check("f1_sb_left", 32'(exp_q.size()), 32'd0);

        // Frame 2: P=0, frame_len=3, FIFO holds more than needed
        reset_stats();
        wr_ptr = rd_ptr;
        push_fifo(4'h9, 4'h1); push_fifo(4'h2, 4'h3); push_fifo(4'h4, 4'h5);
        push_fifo(4'h6, 4'h7); push_fifo(4'h8, 4'h9);
        push_preamble(8);
        exp_q.push_back(8'h91); exp_q.push_back(8'h23); exp_q.push_back(8'h45);
        exp_gap = 1;
        start_frame(3, 0);
        run_to_done(100);
        repeat (3) cyc();
        check("f2_first_valid", 32'(first_valid - t_start), 32'd1);
        check("f2_n_valid", 32'(n_valid), 32'd11);
        check("f2_n_busy", 32'(n_busy), 32'd11);
        check("f2_n_done", 32'(n_done), 32'd1);
        check("f2_n_pop", 32'(n_pop), 32'd3);
        check("f2_sb_left", 32'(exp_q.size()), 32'd0);

        // Frame 3: underrun after payload symbol 1, refill 10 cycles later
        reset_stats();
        wr_ptr = rd_ptr;
        push_fifo(4'hA, 4'hB);
        push_preamble(8);
        exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hEF);
        chk_gap = 1'b0;
        start_frame(3, 1);
        n = 0;
        while (n_pop < 1 && n < 100) begin
            cyc();
            n++;
        end
        repeat (10) cyc();
        check("f3_underrun_set", 32'(bus.underrun), 32'd1);
        check("f3_stalled_valid", 32'(n_valid), 32'd9);
        push_fifo(4'hC, 4'hD); push_fifo(4'hE, 4'hF);
        run_to_done(100);
        repeat (3) cyc();
        check("f3_underrun_sticky", 32'(bus.underrun), 32'd1);
        check("f3_n_pop", 32'(n_pop), 32'd3);
        check("f3_n_valid", 32'(n_valid), 32'd11);
        check("f3_n_done", 32'(n_done), 32'd1);
        check("f3_sb_left", 32'(exp_q.size()), 32'd0);

        // Frame 4: frame_len=0, preamble only; start clears underrun
        reset_stats();
        push_preamble(8);
        chk_gap = 1'b1;
        exp_gap = 3;
        start_frame(0, 2);
        check("f4_underrun_cleared", 32'(bus.underrun), 32'd0);
        run_to_done(100);
        repeat (3) cyc();
        check("f4_n_valid", 32'(n_valid), 32'd8);
        check("f4_n_pop", 32'(n_pop), 32'd0);
        check("f4_n_done", 32'(n_done), 32'd1);
        check("f4_done_with_last", 32'(done_at - last_valid), 32'd0);
        check("f4_sb_left", 32'(exp_q.size()), 32'd0);

        // Frame 5: abort after two payload pops
        reset_stats();
        wr_ptr = rd_ptr;
        push_fifo(4'h1, 4'h1); push_fifo(4'h2, 4'h2); push_fifo(4'h3, 4'h3);
        push_fifo(4'h4, 4'h4); push_fifo(4'h5, 4'h5);
        push_preamble(8);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_gap = 1;
        start_frame(5, 0);
        n = 0;
        while (n_pop < 2 && n < 100) begin
            cyc();
            n++;
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        repeat (10) cyc();
        check("f5_n_pop", 32'(n_pop), 32'd2);
        check("f5_n_valid", 32'(n_valid), 32'd10);
        check("f5_n_done", 32'(n_done), 32'd0);
        check("f5_busy", 32'(bus.busy), 32'd0);
        check("f5_sb_left", 32'(exp_q.size()), 32'd0);

        // Frame 6: reset mid-preamble
        reset_stats();
        wr_ptr = rd_ptr;
        push_fifo(4'h6, 4'h6); push_fifo(4'h7, 4'h7);
        push_preamble(3);
        exp_gap = 2;
        start_frame(2, 1);
        n = 0;
        while (n_valid < 3 && n < 100) begin
            cyc();
            n++;
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_zero_outputs("f6_reset");
        repeat (10) cyc();
        check("f6_n_valid", 32'(n_valid), 32'd3);
        check("f6_n_pop", 32'(n_pop), 32'd0);
        check("f6_n_done", 32'(n_done), 32'd0);
        check("f6_sb_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
